// File: rtl/mmu_bus_master_if.sv
// CPU request/response and Wishbone-style bus signals of mmu_bus_master.
// The master modport is the block's view; slave is the view of whatever drives it.
interface mmu_bus_master_if #(
    parameter int LINE_WORDS = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [31:0]             req_addr;
    logic [3:0]              req_strb;
    logic [31:0]             req_wdata;
    logic                    rsp_valid;
    logic                    rsp_err;
    logic [32*LINE_WORDS-1:0] rsp_rdata;
    logic                    m_cyc;
    logic                    m_we;
    logic [3:0]              m_strb;
    logic [31:0]             m_addr;
    logic [31:0]             m_data_o;
    logic                    m_ack;
    logic [31:0]             m_data_i;

    modport master (
        input  req_valid, req_we, req_addr, req_strb, req_wdata, m_ack, m_data_i,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               m_cyc, m_we, m_strb, m_addr, m_data_o
    );

    modport slave (
        output req_valid, req_we, req_addr, req_strb, req_wdata, m_ack, m_data_i,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               m_cyc, m_we, m_strb, m_addr, m_data_o
    );
endinterface

// File: rtl/mmu_bus_master.sv
// Bus master for the CPU memory unit: line fills as LINE_WORDS single-word beats, or one strobed write.
// Optional per-beat ack timeout enabled by defining BUS_TIMEOUT_EN.
module mmu_bus_master #(
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    mmu_bus_master_if.master bus
);
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    if (LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mmu_bus_master: LINE_WORDS must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_GAP,
        ST_RESP
    } state_e;

    state_e                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     m_cyc_q, m_cyc_d;
    logic                     m_we_q, m_we_d;
    logic [3:0]               m_strb_q, m_strb_d;
    logic [31:0]              m_addr_q, m_addr_d;
    logic [31:0]              m_data_o_q, m_data_o_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [32*LINE_WORDS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                     last_beat;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // A write is always a single beat; a read ends on the last word of the line.
    assign last_beat = m_we_q || (beat_q == LAST_BEAT);

    // NOTE: every variable gets its hold/default value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        m_cyc_d     = m_cyc_q;
        m_we_d      = m_we_q;
        m_strb_d    = m_strb_q;
        m_addr_d    = m_addr_q;
        m_data_o_d  = m_data_o_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef BUS_TIMEOUT_EN
        tmo_d       = tmo_q;
        rsp_err_d   = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_d = ST_BUS;
                    beat_d  = '0;
                    m_cyc_d = 1'b1;
`ifdef BUS_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    if (bus.req_we) begin
                        m_we_d     = 1'b1;
                        m_addr_d   = {bus.req_addr[31:2], 2'b00};
                        m_strb_d   = bus.req_strb;
                        m_data_o_d = bus.req_wdata;
                    end else begin
                        m_we_d   = 1'b0;
                        m_addr_d = {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
                        m_strb_d = 4'hF;
                    end
                end
            end

            ST_BUS: begin
                if (bus.m_ack) begin
                    if (!m_we_q) begin
                        rsp_rdata_d[32*beat_q +: 32] = bus.m_data_i;
                    end
                    m_cyc_d = 1'b0;
                    if (last_beat) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
`ifdef BUS_TIMEOUT_EN
                // An ack on the expiry cycle is taken above; only a silent slave times out.
                else if (tmo_q == TMO_LAST) begin
                    m_cyc_d     = 1'b0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end

            ST_GAP: begin
                state_d  = ST_BUS;
                m_cyc_d  = 1'b1;
                m_addr_d = m_addr_q + 32'd4;
                beat_d   = beat_q + BEAT_W'(1);
`ifdef BUS_TIMEOUT_EN
                tmo_d    = '0;
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                m_cyc_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            m_cyc_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_strb_q    <= 4'h0;
            m_addr_q    <= 32'h0;
            m_data_o_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            // NOTE: the line buffer is reset too, since software may look at rsp_rdata before any fill.
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            m_cyc_q     <= m_cyc_d;
            m_we_q      <= m_we_d;
            m_strb_q    <= m_strb_d;
            m_addr_q    <= m_addr_d;
            m_data_o_q  <= m_data_o_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.m_cyc     = m_cyc_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_strb    = m_strb_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_data_o  = m_data_o_q;
endmodule

// File: tb/tb_mmu_bus_master.sv
// Self-checking bench for mmu_bus_master: directed and random transactions against a beat/latency model.
// Define BUS_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_mmu_bus_master;
    localparam int LW  = 4;
    localparam int TMO = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic [31:0] exp_line [LW];

    mmu_bus_master_if #(.LINE_WORDS(LW)) bus ();

    mmu_bus_master #(
        .LINE_WORDS    (LW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32*LW-1:0] obs, input logic [32*LW-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*LW-1:0] pack_line();
        logic [32*LW-1:0] v;
        v = '0;
        for (int i = 0; i < LW; i++) v[32*i +: 32] = exp_line[i];
        return v;
    endfunction

    // One CPU transaction: drives the request, plays the slave and scores beats, latency and the line.
    task automatic do_op(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input int delay, input logic [31:0] key,
                         input bit noise, input int stall_beat);
        int          nb, beat, w, n, gap, exp_n, stall_run;
        logic [31:0] base, exp_addr, d;
        logic        err_seen, exp_err;
        bit          done;

        nb   = we ? 1 : LW;
        base = we ? {addr[31:2], 2'b00} : (addr & ~32'(LW * 4 - 1));

        @(negedge clk);
        check("ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_strb  = strb;
        bus.req_wdata = wdata;
        @(posedge clk);

        beat = 0; w = 0; n = 0; gap = 0; done = 0; stall_run = 0; err_seen = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            bus.req_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            if (bus.rsp_valid) begin
                done          = 1;
                err_seen      = bus.rsp_err;
                bus.req_valid = 1'b0;
                bus.m_ack     = 1'b0;
            end else begin
                check("ready_busy", bus.req_ready, 1'b0);
                if (bus.m_cyc) begin
                    exp_addr = base + 32'(4 * beat);
                    check("m_addr", bus.m_addr, exp_addr);
                    check("m_we", bus.m_we, we);
                    check("m_strb", bus.m_strb, we ? strb : 4'hF);
                    if (we) check("m_data_o", bus.m_data_o, wdata);
                    if (beat > 0 && w == 0) check("gap_len", 32'(gap), 32'd1);
                    gap = 0;
                    if (beat == stall_beat) stall_run++;
                    if (beat != stall_beat && w == delay) begin
                        d            = key ^ exp_addr;
                        bus.m_ack    = 1'b1;
                        bus.m_data_i = d;
                        if (!we) exp_line[beat] = d;
                        beat++;
                        w = 0;
                    end else begin
                        bus.m_ack    = 1'b0;
                        bus.m_data_i = 32'h0;
                        w++;
                    end
                end else begin
                    gap++;
                    bus.m_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.m_data_i = $urandom;
                end
            end
        end
        bus.req_valid = 1'b0;
        bus.m_ack     = 1'b0;

        exp_err = 1'b0;
        exp_n   = nb * (1 + delay) + (nb - 1) + 1;
`ifdef BUS_TIMEOUT_EN
        if (stall_beat >= 0) begin
            exp_n   = stall_beat * (1 + delay) + stall_beat + TMO + 1;
            exp_err = 1'b1;
            check("stall_cycles", 32'(stall_run), 32'(TMO));
        end
        check("rsp_seen", 1'(done), 1'b1);
        check("latency", 32'(n), 32'(exp_n));
        check("rsp_err", err_seen, exp_err);
`else
        if (stall_beat >= 0) begin
            check("no_rsp", 1'(done), 1'b0);
            check("stall_long", 1'(stall_run >= 100), 1'b1);
            check("cyc_held", bus.m_cyc, 1'b1);
            check("err_low", bus.rsp_err, 1'b0);
        end else begin
            check("rsp_seen", 1'(done), 1'b1);
            check("latency", 32'(n), 32'(exp_n));
            check("rsp_err", err_seen, exp_err);
        end
`endif
        check("rsp_rdata", bus.rsp_rdata, pack_line());
        if (done) begin
            @(negedge clk);
            check("ready_after", bus.req_ready, 1'b1);
            check("rsp_pulse", bus.rsp_valid, 1'b0);
        end
    endtask

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        n_checks      = 0;
        n_errors      = 0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_strb  = 4'h0;
        bus.req_wdata = 32'h0;
        bus.m_ack     = 1'b0;
        bus.m_data_i  = 32'h0;
        for (int i = 0; i < LW; i++) exp_line[i] = 32'h0;

        // Reset state, during and after reset
        #2;
        check("rst_cyc", bus.m_cyc, 1'b0);
        check("rst_rsp", bus.rsp_valid, 1'b0);
        check("rst_err", bus.rsp_err, 1'b0);
        check("rst_ready", bus.req_ready, 1'b1);
        check("rst_addr", bus.m_addr, 32'h0);
        check("rst_strb", bus.m_strb, 4'h0);
        check("rst_line", bus.rsp_rdata, pack_line());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_cyc", bus.m_cyc, 1'b0);
        check("post_rst_rsp", bus.rsp_valid, 1'b0);
        check("post_rst_ready", bus.req_ready, 1'b1);

        // Line read, zero-wait slave returning the address as data
        do_op(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, 32'h0, 1'b0, -1);
        check("line_1230", bus.rsp_rdata, 128'h0000123C_00001238_00001234_00001230);

        // Strobed single write leaves the line untouched
        do_op(1'b1, 32'h0000_2002, 4'b1100, 32'hAABB_CCDD, 0, 32'h0, 1'b0, -1);
        check("line_kept", bus.rsp_rdata, 128'h0000123C_00001238_00001234_00001230);

        // Five wait states per beat, with request and ack noise while busy
        do_op(1'b0, 32'h0000_5A48, 4'h0, 32'h0, 5, $urandom, 1'b1, -1);

        // Topmost line of the address space
        do_op(1'b0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1, $urandom, 1'b1, -1);

        for (int i = 0; i < 10; i++) begin
            do_op(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                  $urandom_range(0, 3), $urandom, 1'b1, -1);
        end

        // Reset while the second beat of a read is on the bus
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0300;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.m_ack     = 1'b1;
        bus.m_data_i  = 32'hDEAD_0300;
        @(negedge clk);
        bus.m_ack     = 1'b0;
        @(negedge clk);
        check("beat2_cyc", bus.m_cyc, 1'b1);
        check("beat2_addr", bus.m_addr, 32'h0000_0304);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", bus.m_cyc, 1'b0);
        check("rst_mid_rsp", bus.rsp_valid, 1'b0);
        check("rst_mid_ready", bus.req_ready, 1'b1);
        for (int i = 0; i < LW; i++) exp_line[i] = 32'h0;
        check("rst_mid_line", bus.rsp_rdata, pack_line());
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b1, 32'h0000_0010, 4'hF, 32'h1357_9BDF, 0, 32'h0, 1'b0, -1);

`ifdef BUS_TIMEOUT_EN
        // Slave goes silent on the third beat: timeout, first two words updated
        do_op(1'b0, 32'h0000_4000, 4'h0, 32'h0, 0, 32'h5555_0000, 1'b0, 2);
`else
        // Slave never acks: the master waits for good, then reset recovers it
        do_op(1'b0, 32'h0000_4000, 4'h0, 32'h0, 0, 32'h5555_0000, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("hang_rst_cyc", bus.m_cyc, 1'b0);
        for (int i = 0; i < LW; i++) exp_line[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        do_op(1'b0, 32'h0000_7000, 4'h0, 32'h0, 2, $urandom, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
